regfile_wb_arbiter: RTL

//  Writeback arbiter in front of the regfile single write port (addrw/wdata/we).
//  - Merges two result sources: ALU (single-cycle, never stalled) and LSU/long-latency unit (valid/ready).
//  - LSU results wait in a small FIFO and drain on cycles when the ALU does not write.
//  - Newer ALU writes squash older queued writes to the same register (WAW-safe).
//  - Exports a pending-write mask used by issue logic for hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU results go straight to the regfile port, LSU results queue and drain on idle cycles.
// Optional trace output enabled by defining WB_TRACE_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_we,
  input  logic [4:0]    alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_addr,
  input  logic [DW-1:0] lsu_data,
  output logic [4:0]    addrw,
  output logic [DW-1:0] wdata,
  output logic          we,
  output logic [31:0]   pending,
  input  logic [31:0]   clkcounter
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [DEPTH-1:0] live_next;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic [31:0]      pend_vec [DEPTH];

  logic full, alu_ok, pop, push, enq;

  function automatic logic writable(input logic [4:0] a);
    return !(a == 5'd0 || a == 5'd1 || a == 5'd31);
  endfunction

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign lsu_ready = !full;
  assign alu_ok    = alu_we && writable(alu_addr);
  assign pop       = !alu_ok && (count_reg != '0);
  assign push      = lsu_valid && lsu_ready;
  assign enq       = push && writable(lsu_addr);

  // A same-cycle push counts as older than the ALU write, so it can be born dead.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic       slot_wr;
    logic [4:0] slot_addr;
    assign slot_wr   = enq && (wr_ptr_reg == AW'(gi));
    assign slot_addr = slot_wr ? lsu_addr : addr_mem[gi];

    always_comb begin
      live_next[gi] = live_reg[gi];
      if (pop && (rd_ptr_reg == AW'(gi))) live_next[gi] = 1'b0;
      if (slot_wr) live_next[gi] = 1'b1;
      if (alu_ok && (slot_addr == alu_addr)) live_next[gi] = 1'b0;
    end

    assign pend_vec[gi] = live_reg[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) pending = pending | pend_vec[i];
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= lsu_addr;
      data_mem[wr_ptr_reg] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_reg   <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      we         <= 1'b0;
      addrw      <= '0;
      wdata      <= '0;
    end else begin
      live_reg  <= live_next;
      count_reg <= count_reg + (AW+1)'(enq) - (AW+1)'(pop);
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (alu_ok) begin
        we    <= 1'b1;
        addrw <= alu_addr;
        wdata <= alu_data;
      end else if (pop) begin
        // A dead head still burns its drain slot.
        we <= live_reg[rd_ptr_reg];
        if (live_reg[rd_ptr_reg]) begin
          addrw <= addr_mem[rd_ptr_reg];
          wdata <= data_mem[rd_ptr_reg];
        end
      end else begin
        we <= 1'b0;
      end
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (we) $write("[W%0d=%0d@%0d]", addrw, wdata, clkcounter);
  end
`else
  logic unused_clkcounter;
  assign unused_clkcounter = ^clkcounter;
`endif

endmodule
